// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter among NREQ byte requesters.
// Supports locked multi-byte packets, a lock idle timeout and a busy-rise watchdog.
module uart_tx_sched #(
   parameter int unsigned NREQ         = 4,
   parameter int unsigned LOCK_TIMEOUT = 1024,
   parameter int unsigned BUSY_WAIT    = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [8*NREQ-1:0] req_data,
   input  logic [NREQ-1:0]   req_last,
   output logic [NREQ-1:0]   req_ready,
   output logic              tx_en,
   output logic              tx_begin,
   output logic [7:0]        tx_data,
   input  logic              tx_busy,
   output logic [2:0]        grant,
   output logic              locked,
   output logic              err
);

   localparam int unsigned LtW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT + 1) : 1;
   localparam int unsigned BwW = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT + 1) : 1;
   localparam logic [LtW-1:0] LockLast = LtW'((LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0);
   localparam logic [BwW-1:0] BusyLast = BwW'((BUSY_WAIT > 0) ? BUSY_WAIT - 1 : 0);
   localparam logic [3:0]     NreqW    = 4'(NREQ);

   typedef enum logic [1:0] {StArb, StStart, StWaitBusy, StSend} state_e;

   state_e           state_q, state_d;
   logic [2:0]       rr_ptr_q, rr_ptr_d;
   logic [2:0]       grant_q, grant_d;
   logic             locked_q, locked_d;
   logic             err_q, err_d;
   logic [7:0]       tx_data_q, tx_data_d;
   logic [LtW-1:0]   lock_cnt_q, lock_cnt_d;
   logic [BwW-1:0]   busy_cnt_q, busy_cnt_d;

   // Requester vectors padded to the 8-entry index space of grant.
   logic [7:0]       valid_pad;
   logic [7:0]       last_pad;
   logic [63:0]      data_pad;
   logic             sel_found;
   logic [2:0]       sel_idx;
   logic [3:0]       cand;
   logic [3:0]       rr_next;
   logic [7:0]       ready_pad;
   logic             arb_go;
   logic             accept;

   assign valid_pad = 8'(req_valid);
   assign last_pad  = 8'(req_last);
   assign data_pad  = 64'(req_data);

   // Walk the ring from the far end so the candidate closest to rr_ptr wins.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = grant_q;
      cand      = 4'd0;
      if (locked_q) begin
         sel_found = valid_pad[grant_q];
      end else begin
         for (int k = NREQ - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr_q} + 4'(k);
            if (cand >= NreqW) begin
               cand = cand - NreqW;
            end
            if (valid_pad[cand[2:0]]) begin
               sel_found = 1'b1;
               sel_idx   = cand[2:0];
            end
         end
      end
   end

   assign arb_go    = (state_q == StArb) && en && !tx_busy && !reset;
   assign accept    = arb_go && sel_found;
   assign ready_pad = accept ? (8'b1 << sel_idx) : 8'b0;
   assign req_ready = ready_pad[NREQ-1:0];

   always_comb begin
      rr_next = {1'b0, sel_idx} + 4'd1;
      if (rr_next == NreqW) begin
         rr_next = 4'd0;
      end
   end

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      grant_d    = grant_q;
      locked_d   = locked_q;
      err_d      = err_q;
      tx_data_d  = tx_data_q;
      lock_cnt_d = '0;
      busy_cnt_d = '0;
      tx_begin   = 1'b0;
      unique case (state_q)
         StArb: begin
            if (accept) begin
               tx_data_d = data_pad[{sel_idx, 3'b000} +: 8];
               grant_d   = sel_idx;
               rr_ptr_d  = rr_next[2:0];
               locked_d  = ~last_pad[sel_idx];
               state_d   = StStart;
            end else if (locked_q && (LOCK_TIMEOUT != 0) && !valid_pad[grant_q]) begin
               if (lock_cnt_q == LockLast) begin
                  locked_d = 1'b0;
               end else begin
                  lock_cnt_d = lock_cnt_q + 1'b1;
               end
            end
         end
         StStart: begin
            tx_begin = 1'b1;
            state_d  = StWaitBusy;
         end
         StWaitBusy: begin
            if (tx_busy) begin
               state_d = StSend;
            end else if (busy_cnt_q == BusyLast) begin
               // Transmitter never acknowledged: drop the byte, keep any lock.
               err_d   = 1'b1;
               state_d = StArb;
            end else begin
               busy_cnt_d = busy_cnt_q + 1'b1;
            end
         end
         StSend: begin
            if (!tx_busy) begin
               state_d = StArb;
            end
         end
         default: begin
            state_d = StArb;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= StArb;
         rr_ptr_q   <= 3'd0;
         grant_q    <= 3'd0;
         locked_q   <= 1'b0;
         err_q      <= 1'b0;
         tx_data_q  <= 8'h00;
         lock_cnt_q <= '0;
         busy_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         grant_q    <= grant_d;
         locked_q   <= locked_d;
         err_q      <= err_d;
         tx_data_q  <= tx_data_d;
         lock_cnt_q <= lock_cnt_d;
         busy_cnt_q <= busy_cnt_d;
      end
   end

   assign tx_en   = en;
   assign tx_data = tx_data_q;
   assign grant   = grant_q;
   assign locked  = locked_q;
   assign err     = err_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with a small behavioural transmitter model.
module tb_uart_tx_sched;

   localparam int NREQ  = 4;
   localparam int LT    = 16;
   localparam int BW    = 4;
   localparam int FRAME = 6;

   logic        clk = 1'b0;
   logic        reset;
   logic        en;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_last;
   logic [3:0]  req_ready;
   logic        tx_en;
   logic        tx_begin;
   logic [7:0]  tx_data;
   logic        tx_busy;
   logic [2:0]  grant;
   logic        locked;
   logic        err;

   logic        model_on;
   int          busy_cnt;
   int          total = 0;
   int          bad = 0;

   uart_tx_sched #(.NREQ(NREQ), .LOCK_TIMEOUT(LT), .BUSY_WAIT(BW)) dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_last  (req_last),
      .req_ready (req_ready),
      .tx_en     (tx_en),
      .tx_begin  (tx_begin),
      .tx_data   (tx_data),
      .tx_busy   (tx_busy),
      .grant     (grant),
      .locked    (locked),
      .err       (err)
   );

   always #5 clk = ~clk;

   // Transmitter: busy rises on the edge that samples tx_begin, stays high FRAME cycles.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_busy  <= 1'b0;
         busy_cnt <= 0;
      end else if (model_on && tx_begin) begin
         tx_busy  <= 1'b1;
         busy_cnt <= FRAME;
      end else if (busy_cnt > 0) begin
         busy_cnt <= busy_cnt - 1;
         if (busy_cnt == 1) tx_busy <= 1'b0;
      end
   end

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; en = 1'b1; model_on = 1'b1;
      req_valid = '0; req_last = '0; req_data = '0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
   endtask

   task automatic wait_ready();
      bit ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         #1;
         if (req_ready != 4'b0) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      total++;
      if (!ok) begin bad++; $display("FAIL wait_ready: req_ready=%b required nonzero", req_ready); end
   endtask

   // Ends at a negedge inside the last SEND cycle (busy already low).
   task automatic wait_frame();
      bit up = 1'b0;
      bit down = 1'b0;
      for (int i = 0; i < 20 && !up; i++) begin
         @(negedge clk); #1;
         if (tx_busy) up = 1'b1;
      end
      for (int i = 0; i < 40 && up && !down; i++) begin
         @(negedge clk); #1;
         if (!tx_busy) down = 1'b1;
      end
      total++;
      if (!(up && down)) begin bad++; $display("FAIL wait_frame: up=%0d down=%0d required 1 1", up, down); end
   endtask

   task automatic test_reset();
      @(negedge clk); #1;
      total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL rst_ready: got %b want 0000", req_ready); end
      total++; if (grant !== 3'd0) begin bad++; $display("FAIL rst_grant: got %0d want 0", grant); end
      total++; if (locked !== 1'b0) begin bad++; $display("FAIL rst_locked: got %b want 0", locked); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", err); end
      total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL rst_txdata: got %h want 00", tx_data); end
      total++; if (tx_begin !== 1'b0) begin bad++; $display("FAIL rst_begin: got %b want 0", tx_begin); end
      total++; if (tx_en !== 1'b1) begin bad++; $display("FAIL tx_en_hi: got %b want 1", tx_en); end
      en = 1'b0; #1;
      total++; if (tx_en !== 1'b0) begin bad++; $display("FAIL tx_en_lo: got %b want 0", tx_en); end
   endtask

   task automatic test_single();
      do_reset();
      req_data[23:16] = 8'hA5; req_last = 4'b0100; req_valid = 4'b0100; #1;
      total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL single_ready: got %b want 0100", req_ready); end
      @(negedge clk); #1;
      req_valid = 4'b0;
      total++; if (tx_begin !== 1'b1) begin bad++; $display("FAIL single_begin: got %b want 1", tx_begin); end
      total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL single_ready_off: got %b want 0000", req_ready); end
      total++; if (grant !== 3'd2) begin bad++; $display("FAIL single_grant: got %0d want 2", grant); end
      total++; if (locked !== 1'b0) begin bad++; $display("FAIL single_locked: got %b want 0", locked); end
      @(negedge clk); #1;
      total++; if (tx_begin !== 1'b0) begin bad++; $display("FAIL single_begin_1cyc: got %b want 0", tx_begin); end
      for (int i = 0; i < 40 && tx_busy; i++) begin
         total++; if (tx_data !== 8'hA5) begin bad++; $display("FAIL single_hold: got %h want a5", tx_data); end
         @(negedge clk); #1;
      end
      total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL single_frame_end: busy=%b want 0", tx_busy); end
      @(negedge clk); #1;
      total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL single_no_repeat: got %b want 0000", req_ready); end
   endtask

   task automatic test_fairness();
      int exp_ord[6] = '{0, 1, 2, 3, 0, 1};
      do_reset();
      req_data = 32'h44332211; req_last = 4'hF; req_valid = 4'hF;
      for (int n = 0; n < 6; n++) begin
         wait_ready();
         total++;
         if (req_ready !== 4'(1 << exp_ord[n])) begin
            bad++; $display("FAIL fair_ready[%0d]: got %b want onehot %0d", n, req_ready, exp_ord[n]);
         end
         @(negedge clk); #1;
         total++;
         if (grant !== 3'(exp_ord[n])) begin
            bad++; $display("FAIL fair_grant[%0d]: got %0d want %0d", n, grant, exp_ord[n]);
         end
         total++;
         if (tx_data !== 8'(8'h11 * (exp_ord[n] + 1))) begin
            bad++; $display("FAIL fair_data[%0d]: got %h want %h", n, tx_data, 8'(8'h11 * (exp_ord[n] + 1)));
         end
      end
      req_valid = 4'b0;
      wait_frame();
   endtask

   task automatic test_locked();
      do_reset();
      req_data[15:8] = 8'h11; req_last = 4'b0000; req_valid = 4'b0010;
      wait_ready();
      total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL lock_r1: got %b want 0010", req_ready); end
      @(negedge clk); #1;
      total++; if (locked !== 1'b1) begin bad++; $display("FAIL lock_set: got %b want 1", locked); end
      req_data[15:8] = 8'h12; req_data[7:0] = 8'h20; req_last = 4'b0001; req_valid = 4'b0011;
      wait_ready();
      total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL lock_r2: got %b want 0010", req_ready); end
      @(negedge clk); #1;
      total++; if (tx_data !== 8'h12) begin bad++; $display("FAIL lock_d2: got %h want 12", tx_data); end
      total++; if (locked !== 1'b1) begin bad++; $display("FAIL lock_hold: got %b want 1", locked); end
      req_data[15:8] = 8'h13; req_last = 4'b0011;
      wait_ready();
      total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL lock_r3: got %b want 0010", req_ready); end
      @(negedge clk); #1;
      req_valid = 4'b0001;
      total++; if (tx_data !== 8'h13) begin bad++; $display("FAIL lock_d3: got %h want 13", tx_data); end
      total++; if (locked !== 1'b0) begin bad++; $display("FAIL lock_release: got %b want 0", locked); end
      wait_ready();
      total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL lock_r0: got %b want 0001", req_ready); end
      @(negedge clk); #1;
      req_valid = 4'b0;
      total++; if (grant !== 3'd0 || tx_data !== 8'h20) begin
         bad++; $display("FAIL lock_g0: grant=%0d data=%h want 0 20", grant, tx_data);
      end
      wait_frame();
   endtask

   task automatic test_lock_timeout();
      do_reset();
      req_data[31:24] = 8'h33; req_last = 4'b0000; req_valid = 4'b1000;
      wait_ready();
      total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL lto_r3: got %b want 1000", req_ready); end
      @(negedge clk); #1;
      req_valid = 4'b0001; req_last = 4'b0001; req_data[7:0] = 8'h44;
      wait_frame();
      for (int i = 1; i <= LT; i++) begin
         @(negedge clk); #1;
         total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL lto_block[%0d]: got %b want 0000", i, req_ready); end
      end
      total++; if (locked !== 1'b1) begin bad++; $display("FAIL lto_still: got %b want 1", locked); end
      @(negedge clk); #1;
      total++; if (locked !== 1'b0) begin bad++; $display("FAIL lto_drop: got %b want 0", locked); end
      total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL lto_r0: got %b want 0001", req_ready); end
      @(negedge clk); #1;
      req_valid = 4'b0;
      total++; if (grant !== 3'd0) begin bad++; $display("FAIL lto_g0: got %0d want 0", grant); end
      wait_frame();
   endtask

   task automatic test_busy_missing();
      do_reset();
      model_on = 1'b0;
      req_data[23:16] = 8'h77; req_last = 4'b0101; req_valid = 4'b0100;
      wait_ready();
      @(negedge clk); #1;
      req_valid = 4'b0001;
      total++; if (tx_begin !== 1'b1) begin bad++; $display("FAIL bm_begin: got %b want 1", tx_begin); end
      for (int k = 1; k <= BW + 1; k++) begin
         @(negedge clk); #1;
         if (k == 1) begin
            total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL bm_wait_ready: got %b want 0000", req_ready); end
         end
         if (k == BW - 1) begin
            total++; if (err !== 1'b0) begin bad++; $display("FAIL bm_err_early: got %b want 0", err); end
         end
         if (k == BW + 1) begin
            total++; if (err !== 1'b1) begin bad++; $display("FAIL bm_err_set: got %b want 1", err); end
            total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL bm_back_arb: got %b want 0001", req_ready); end
         end
      end
      req_valid = 4'b0;
      for (int i = 0; i < 12; i++) @(negedge clk);
      #1;
      total++; if (err !== 1'b1) begin bad++; $display("FAIL bm_sticky: got %b want 1", err); end
      do_reset();
      total++; if (err !== 1'b0) begin bad++; $display("FAIL bm_clear: got %b want 0", err); end
   endtask

   task automatic test_reset_midframe();
      do_reset();
      req_data[15:8] = 8'h5A; req_last = 4'b0000; req_valid = 4'b0010;
      wait_ready();
      @(negedge clk); #1;
      req_valid = 4'b0;
      for (int i = 0; i < 20 && !tx_busy; i++) begin
         @(negedge clk); #1;
      end
      @(negedge clk); #1;
      total++; if (tx_busy !== 1'b1 || tx_data !== 8'h5A) begin
         bad++; $display("FAIL mid_pre: busy=%b data=%h want 1 5a", tx_busy, tx_data);
      end
      reset = 1'b1; #1;
      total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL mid_data: got %h want 00", tx_data); end
      total++; if (locked !== 1'b0 || grant !== 3'd0) begin
         bad++; $display("FAIL mid_lock_grant: locked=%b grant=%0d want 0 0", locked, grant);
      end
      total++; if (tx_begin !== 1'b0 || req_ready !== 4'b0) begin
         bad++; $display("FAIL mid_strobes: begin=%b ready=%b want 0 0000", tx_begin, req_ready);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_enable();
      do_reset();
      en = 1'b0; req_data = 32'h04030201; req_last = 4'hF; req_valid = 4'hF;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); #1;
         total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL en_block[%0d]: got %b want 0000", i, req_ready); end
      end
      en = 1'b1; #1;
      total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL en_first: got %b want 0001", req_ready); end
      @(negedge clk); #1;
      req_valid = 4'b0;
      total++; if (grant !== 3'd0 || tx_data !== 8'h01) begin
         bad++; $display("FAIL en_grant: grant=%0d data=%h want 0 01", grant, tx_data);
      end
      wait_frame();
   endtask

   initial begin
      reset = 1'b1; en = 1'b1; model_on = 1'b1;
      req_valid = 4'hF; req_last = '0; req_data = '0;
      test_reset();
      test_single();
      test_fairness();
      test_locked();
      test_lock_timeout();
      test_busy_missing();
      test_reset_midframe();
      test_enable();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
